// File: rtl/mem_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_read_responder                                                         |
// | Word RAM with a fixed-latency, fully pipelined read response bus.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_read_responder #(
  parameter int LATENCY        = 4,
  parameter int MEM_WORDS_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data_out,
  output logic        o_data_valid,
  output logic [15:0] o_resp_addr,
  output logic [3:0]  o_outstanding
);

  localparam int c_WORDS = 1 << MEM_WORDS_LOG2;

  logic [15:0]               r_mem [c_WORDS];
  logic [MEM_WORDS_LOG2-1:0] w_idx;
  logic                      w_rd;
  logic                      w_wr;
  logic [15:0]               w_rd_data;
  logic                      w_unused_addr0;

  logic [LATENCY-1:0]        r_vld;
  logic [15:0]               r_data [LATENCY];
  logic [15:0]               r_addr [LATENCY];
  logic [3:0]                r_outstanding;

  logic [LATENCY-1:0]        w_nxt_vld;
  logic [LATENCY-1:0]        w_ld;
  logic [15:0]               w_nxt_data [LATENCY];
  logic [15:0]               w_nxt_addr [LATENCY];

  // Higher address bits alias onto the same word; bit 0 is the byte lane.
  assign w_idx          = i_addr[MEM_WORDS_LOG2:1];
  assign w_rd           = i_enable & ~i_wr;
  assign w_wr           = i_enable &  i_wr;
  assign w_rd_data      = r_mem[w_idx];
  assign w_unused_addr0 = i_addr[0];

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= i_data_in;
    end
  end

  generate
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
      if (s == 0) begin : g_first
        assign w_nxt_vld[s]  = w_rd;
        assign w_ld[s]       = w_rd;
        assign w_nxt_data[s] = w_rd_data;
        assign w_nxt_addr[s] = {i_addr[15:1], 1'b0};
      end else begin : g_rest
        assign w_nxt_vld[s]  = r_vld[s-1];
        assign w_ld[s]       = r_vld[s-1];
        assign w_nxt_data[s] = r_data[s-1];
        assign w_nxt_addr[s] = r_addr[s-1];
      end
    end
  endgenerate

  // Payload moves only with a valid entry, so the last stage keeps the last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      r_vld <= w_nxt_vld;
      for (int i = 0; i < LATENCY; i++) begin
        if (w_ld[i]) begin
          r_data[i] <= w_nxt_data[i];
          r_addr[i] <= w_nxt_addr[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + {3'b000, w_rd} - {3'b000, r_vld[LATENCY-1]};
    end
  end

  assign o_data_valid  = r_vld[LATENCY-1];
  assign o_data_out    = r_data[LATENCY-1];
  assign o_resp_addr   = r_addr[LATENCY-1];
  assign o_outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_read_responder                                                      |
// | Randomised and directed bench with a queue-based response model.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_read_responder;

  localparam int LAT  = 4;
  localparam int MWL  = 15;
  localparam int LAT1 = 1;
  localparam int MWL1 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, wr0 = 1'b0;
  logic [15:0] addr0 = '0, din0 = '0;
  logic [15:0] dout0, raddr0;
  logic        dv0;
  logic [3:0]  outst0;

  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, din1 = '0;
  logic [15:0] dout1, raddr1;
  logic        dv1;
  logic [3:0]  outst1;

  mem_read_responder #(.LATENCY(LAT), .MEM_WORDS_LOG2(MWL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_enable(en0), .i_wr(wr0), .i_addr(addr0),
    .i_data_in(din0), .o_data_out(dout0), .o_data_valid(dv0),
    .o_resp_addr(raddr0), .o_outstanding(outst0)
  );

  mem_read_responder #(.LATENCY(LAT1), .MEM_WORDS_LOG2(MWL1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(en1), .i_wr(wr1), .i_addr(addr1),
    .i_data_in(din1), .o_data_out(dout1), .o_data_valid(dv1),
    .o_resp_addr(raddr1), .o_outstanding(outst1)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
    bit          known;
  } resp_t;

  resp_t       q[$];
  logic [15:0] mem_m [int];
  logic [15:0] seen_data[$];
  logic [15:0] seen_addr[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          peak = 0;

  logic        e_vld;
  logic [15:0] e_data, e_addr;
  logic [3:0]  e_out;
  bit          e_known;

  // One clock of dut0 traffic; the model predicts what is visible after the edge.
  task automatic step(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int    idx;
    resp_t r;
    en0 = en; wr0 = wr; addr0 = a; din0 = d;
    @(posedge clk);
    cyc++;
    idx = int'(a[MWL:1]);
    if (en && wr) begin
      mem_m[idx] = d;
    end else if (en) begin
      r.due   = cyc + LAT - 1;
      r.addr  = {a[15:1], 1'b0};
      r.known = mem_m.exists(idx);
      r.data  = r.known ? mem_m[idx] : 16'h0000;
      q.push_back(r);
    end
    @(negedge clk);
    en0 = 1'b0; wr0 = 1'b0;
    e_out   = 4'(q.size());
    e_vld   = 1'b0;
    e_known = 1'b0;
    e_data  = '0;
    e_addr  = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_vld   = 1'b1;
      e_data  = q[0].data;
      e_addr  = q[0].addr;
      e_known = q[0].known;
      void'(q.pop_front());
    end
    if (dv0 === 1'b1) begin
      seen_data.push_back(dout0);
      seen_addr.push_back(raddr0);
    end
    if (int'(outst0) > peak) peak = int'(outst0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dv0 !== 1'b0 || outst0 !== 4'd0 || dout0 !== 16'h0 || raddr0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: dv=%b outst=%0d dout=%h raddr=%h, need 0/0/0000/0000", dv0, outst0, dout0, raddr0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if (dv0 !== 1'b0 || outst0 !== 4'd0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d dv=%b outst=%0d, need 0/0", i, dv0, outst0);
      end
    end
  endtask

  task automatic test_write_read();
    int issue;
    int rise;
    rise = -1;
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b1, 16'h0124, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0125, 16'h0000);
    issue = cyc;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1'b0, 1'b0, 16'h0, 16'h0);
      if (dv0 === 1'b1 && rise < 0) rise = cyc;
      checks++;
      if (dv0 !== e_vld || outst0 !== e_out || (e_vld && (dout0 !== e_data || raddr0 !== e_addr))) begin
        errors++;
        $display("FAIL write_read_cycle: dv=%b outst=%0d dout=%h raddr=%h, need %b/%0d/%h/%h", dv0, outst0, dout0, raddr0, e_vld, e_out, e_data, e_addr);
      end
    end
    checks++;
    if (rise - issue !== LAT - 1 || seen_data.size() != 1) begin
      errors++;
      $display("FAIL write_read_latency: edges=%0d responses=%0d, need %0d/1", rise - issue, seen_data.size(), LAT - 1);
    end else begin
      checks++;
      if (seen_data[0] !== 16'hBEEF || seen_addr[0] !== 16'h0124) begin
        errors++;
        $display("FAIL write_read_data: data=%h addr=%h, need BEEF/0124", seen_data[0], seen_addr[0]);
      end
    end
  endtask

  task automatic test_block_fill();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(16'h0200 + 2 * i), 16'(16'h1000 + i));
    seen_data.delete(); seen_addr.delete();
    peak = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) step(1'b1, 1'b0, 16'(16'h0200 + 2 * i), 16'h0);
      else       step(1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if (dv0 !== e_vld || outst0 !== e_out || (e_vld && (dout0 !== e_data || raddr0 !== e_addr))) begin
        errors++;
        $display("FAIL block_fill_cycle: i=%0d dv=%b outst=%0d dout=%h raddr=%h, need %b/%0d/%h/%h", i, dv0, outst0, dout0, raddr0, e_vld, e_out, e_data, e_addr);
      end
    end
    checks++;
    if (peak != LAT || outst0 !== 4'd0 || seen_data.size() != 8) begin
      errors++;
      $display("FAIL block_fill_counts: peak=%0d final=%0d responses=%0d, need %0d/0/8", peak, outst0, seen_data.size(), LAT);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen_data[i] !== 16'(16'h1000 + i) || seen_addr[i] !== 16'(16'h0200 + 2 * i)) begin
          errors++;
          $display("FAIL block_fill_order: idx=%0d data=%h addr=%h, need %h/%h", i, seen_data[i], seen_addr[i], 16'(16'h1000 + i), 16'(16'h0200 + 2 * i));
        end
      end
    end
  endtask

  task automatic test_snapshot();
    step(1'b1, 1'b1, 16'h0300, 16'h1111);
    seen_data.delete(); seen_addr.delete();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       step(1'b1, 1'b0, 16'h0300, 16'h0);
        1:       step(1'b1, 1'b1, 16'h0300, 16'h2222);
        2:       step(1'b1, 1'b0, 16'h0300, 16'h0);
        default: step(1'b0, 1'b0, 16'h0, 16'h0);
      endcase
      checks++;
      if (dv0 !== e_vld || outst0 !== e_out || (e_vld && (dout0 !== e_data || raddr0 !== e_addr))) begin
        errors++;
        $display("FAIL snapshot_cycle: i=%0d dv=%b outst=%0d dout=%h, need %b/%0d/%h", i, dv0, outst0, dout0, e_vld, e_out, e_data);
      end
    end
    checks++;
    if (seen_data.size() != 2) begin
      errors++;
      $display("FAIL snapshot_count: responses=%0d, need 2", seen_data.size());
    end else if (seen_data[0] !== 16'h1111 || seen_data[1] !== 16'h2222) begin
      errors++;
      $display("FAIL snapshot_data: got %h,%h need 1111,2222", seen_data[0], seen_data[1]);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 16'h0400, 16'h5A5A);
    step(1'b1, 1'b0, 16'h0400, 16'h0);
    for (int i = 0; i < LAT - 1; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (dv0 !== 1'b1 || dout0 !== 16'h5A5A) begin
      errors++;
      $display("FAIL async_pre: dv=%b dout=%h, need 1/5A5A", dv0, dout0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dv0 !== 1'b0 || outst0 !== 4'd0 || dout0 !== 16'h0 || raddr0 !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: dv=%b outst=%0d dout=%h raddr=%h, need 0/0/0000/0000", dv0, outst0, dout0, raddr0);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    seen_data.delete(); seen_addr.delete();
    step(1'b1, 1'b0, 16'h0200, 16'h0);
    step(1'b1, 1'b0, 16'h0202, 16'h0);
    step(1'b1, 1'b0, 16'h0204, 16'h0);
    checks++;
    if (outst0 !== 4'd3 || dv0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: outst=%0d dv=%b, need 3/0", outst0, dv0);
    end
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (outst0 !== 4'd0 || dv0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: outst=%0d dv=%b, need 0/0", outst0, dv0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      checks++;
      if (dv0 !== 1'b0 || outst0 !== 4'd0) begin
        errors++;
        $display("FAIL midreset_drain: i=%0d dv=%b outst=%0d, need 0/0", i, dv0, outst0);
      end
    end
    step(1'b1, 1'b0, 16'h0400, 16'h0);
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (seen_data.size() != 1 || seen_data[0] !== 16'h5A5A) begin
      errors++;
      $display("FAIL midreset_preserve: responses=%0d first=%h, need 1/5A5A", seen_data.size(), (seen_data.size() > 0) ? seen_data[0] : 16'h0);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int          sel;
    for (int i = 0; i < 400; i++) begin
      a   = {1'($urandom_range(0, 1)), 7'd0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))};
      sel = $urandom_range(0, 9);
      if (sel < 4)      step(1'b1, 1'b1, a, 16'($urandom));
      else if (sel < 8) step(1'b1, 1'b0, a, 16'($urandom));
      else              step(1'b0, 1'b0, a, 16'h0);
      checks++;
      if (dv0 !== e_vld || outst0 !== e_out || (e_vld && e_known && (dout0 !== e_data || raddr0 !== e_addr))) begin
        errors++;
        $display("FAIL random_cycle: i=%0d dv=%b outst=%0d dout=%h raddr=%h, need %b/%0d/%h/%h", i, dv0, outst0, dout0, raddr0, e_vld, e_out, e_data, e_addr);
      end
    end
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (outst0 !== 4'd0 || dv0 !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: outst=%0d dv=%b, need 0/0", outst0, dv0);
    end
  endtask

  task automatic test_alias_lat1();
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0010; din1 = 16'h00AA;
    step(1'b0, 1'b0, 16'h0, 16'h0);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0210; din1 = 16'h0000;
    step(1'b0, 1'b0, 16'h0, 16'h0);
    en1 = 1'b0;
    checks++;
    if (dv1 !== 1'b1 || dout1 !== 16'h00AA || raddr1 !== 16'h0210 || outst1 !== 4'd1) begin
      errors++;
      $display("FAIL alias_lat1_resp: dv=%b dout=%h raddr=%h outst=%0d, need 1/00AA/0210/1", dv1, dout1, raddr1, outst1);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    checks++;
    if (dv1 !== 1'b0 || outst1 !== 4'd0) begin
      errors++;
      $display("FAIL alias_lat1_drop: dv=%b outst=%0d, need 0/0", dv1, outst1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_block_fill();
    test_snapshot();
    test_async_reset();
    test_reset_mid_op();
    test_random();
    test_alias_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Main-memory side of the cache-fill protocol.
- Accepts word read and write requests from the cache-fill controller and cache write-through path.
- Returns read data on a fixed-latency, fully pipelined response bus: one request per cycle, up to LATENCY reads in flight.
- Each response carries data_valid and the echoed address, so the fill controller can write the data array and detect the requested word.

Parameters:
- LATENCY, 4, cycles from read request to data_valid. Legal range 1..8.
- MEM_WORDS_LOG2, 15, log2 of the number of 16-bit words in the array.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  request strobe; sampled on each rising edge.
- wr  input  1  1 = write request, 0 = read request; qualified by enable.
- addr  input  16  byte address; addr[0] is ignored (word aligned).
- data_in  input  16  write data; qualified by enable & wr.
- data_out  output  16  read data; meaningful only while data_valid=1.
- data_valid  output  1  read response strobe; high for exactly 1 cycle per read.
- resp_addr  output  16  word-aligned address (bit 0 = 0) of the read being returned.
- outstanding  output  4  number of reads accepted but not yet returned (0..LATENCY).

Behaviour:
- Word index is addr[MEM_WORDS_LOG2:1]. Higher address bits are ignored, so addresses alias.
- Array is a word RAM with no reset. Contents are X until written.
- Reset (rst_n=0, asynchronous): clears all pipeline stage valid bits.
  - data_valid=0, data_out=0, resp_addr=0, outstanding=0, all immediately and without a clock.
  - Array contents are preserved.
  - Reads in flight when reset asserts are discarded and never returned.
- Write (enable=1, wr=1 at edge k): array[word] <= data_in at edge k. No response, no data_valid, no effect on outstanding.
- Read (enable=1, wr=0 at edge k):
  - Array is read at issue, capturing the value after any write at an earlier edge.
  - Value and address enter stage 1 of a LATENCY-deep valid/data/addr shift pipeline.
  - Pipeline advances every cycle and is never stalled.
  - After edge k+LATENCY-1: data_valid=1, data_out=captured word, resp_addr={addr[15:1],1'b0}.
  - All three drop after edge k+LATENCY unless another read follows.
  - LATENCY=1 means the response is visible in the cycle after the issue edge.
- Back-to-back reads on consecutive edges give consecutive data_valid cycles, in issue order. No reordering, no bubbles.
- A write to address A after a read of A is in flight does not change that read's returned data (snapshot at issue).
- A read of A issued at the edge after a write to A returns the new data.
- enable=0: nothing enters the pipeline. Stages still drain.
- outstanding: incremented by a read issue and decremented by a response leaving the last stage. The same edge can do both, leaving it unchanged.
- Single port: a write and a read cannot be requested in the same cycle; wr selects one.
- data_out holds its last returned value while data_valid=0. Consumers must not rely on this.

Test Plan:
- Reset and idle:
  - rst_n=0 mid-cycle -> data_valid=0, outstanding=0 immediately, with no clock edge required.
  - Release reset, 10 idle cycles -> data_valid stays 0.
- Single write then read:
  - Write 0xBEEF to 0x0124, then read 0x0125 (addr[0] ignored).
  - -> exactly LATENCY=4 cycles later, one cycle of data_valid=1 with data_out=0xBEEF, resp_addr=0x0124.
- Block fill:
  - Preload 0x0200..0x020E with 0x1000..0x1007.
  - Issue 8 reads on 8 consecutive cycles, addresses 0x0200,0x0202,...,0x020E.
  - -> 8 consecutive data_valid cycles, data 0x1000..0x1007 in order, outstanding peaks at 4, then returns to 0.
- Snapshot hazard:
  - Read 0x0300 (holding 0x1111); next cycle write 0x2222 to 0x0300; next cycle read 0x0300 again.
  - -> first response 0x1111, second response 0x2222.
- Reset mid-operation:
  - Issue 3 reads, then assert rst_n=0 for 1 cycle before any response returns.
  - -> no data_valid for those reads, outstanding=0.
  - Subsequent read of a previously written address returns the pre-reset array value.
- Parameter and aliasing:
  - Rebuild with LATENCY=1 and MEM_WORDS_LOG2=8.
  - Write 0x00AA to 0x0010; read 0x0210.
  - -> data_valid in the next cycle with 0x00AA (aliasing above bit 8), resp_addr=0x0210.
